trdb_packet_sched: RTL and testbench

Packet scheduler between the trace encoder and the trace sink. Arbitrates round-robin between two packet requesters, the encoder packet output and the software user-packet port, at packet granularity. Latches the granted 128-bit packet and serializes it into 32-bit words on a valid/ready stream toward the output FIFO/APB readout. Word count is derived from the packet bit length.

---
 rtl/trdb_pkg.sv | 35 +++
 rtl/trdb_rr_arb2.sv | 31 +++
 rtl/trdb_packet_sched.sv | 180 ++++++++++++++++++
 tb/tb_trdb_packet_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// trdb_pkg: shared constants, the scheduler state type and the packet slice view.
package trdb_pkg;

    localparam int PKT_TOTAL  = 128;
    localparam int PKT_WORD_W = 32;
    localparam int PKT_LEN_W  = 8;
    localparam int PKT_WORDS  = PKT_TOTAL / PKT_WORD_W;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } sched_state_t;

    // Flat packet bits overlaid with a word-indexed view, word 0 = LSBs.
    typedef union packed {
        logic [PKT_TOTAL-1:0]                  flat;
        logic [PKT_WORDS-1:0][PKT_WORD_W-1:0]  words;
    } pkt_slice_t;

    // Keeps only the bits of word 'idx' that lie below the packet length.
    function automatic logic [PKT_WORD_W-1:0] tail_mask(input logic [PKT_LEN_W:0] len,
                                                        input logic [PKT_LEN_W:0] idx);
        logic [PKT_WORD_W-1:0] m;
        int base;
        base = int'(idx) * PKT_WORD_W;
        for (int b = 0; b < PKT_WORD_W; b++) begin
            m[b] = ((base + b) < int'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/trdb_rr_arb2.sv
// trdb_rr_arb2: two-input round-robin arbiter; the source not granted last wins a tie.
module trdb_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;

    // Tie goes to the source that did not win last; a lone requester always wins.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Pointer remembers the last winner; starts at 1 so source 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/trdb_packet_sched.sv
// trdb_packet_sched: round-robin packet scheduler that serializes 128-bit packets into
// 32-bit words. Optional header word before the payload: define TRDB_PKT_HEADER_EN.
module trdb_packet_sched #(
    parameter int PACKET_TOTAL = 128,
    parameter int WORD_W       = 32,
    parameter int LEN_W        = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [1:0]                src_valid_i,
    output logic [1:0]                src_ready_o,
    input  logic [2*PACKET_TOTAL-1:0] src_bits_i,
    input  logic [2*LEN_W-1:0]        src_len_i,
    output logic [WORD_W-1:0]         word_o,
    output logic                      word_valid_o,
    output logic                      word_last_o,
    input  logic                      word_ready_i,
    output logic                      busy_o,
    output logic [31:0]               pkt_cnt_o
);
    import trdb_pkg::*;

    localparam int SHIFT = $clog2(WORD_W);
    localparam int IDX_W = $clog2(PKT_WORDS);

    sched_state_t              state_q, state_d;
    logic [1:0]                gnt;
    logic                      grant;
    logic                      hs;
    logic [PACKET_TOTAL-1:0]   sel_bits;
    logic [LEN_W-1:0]          sel_len, clamp_len;
    logic [LEN_W:0]            sel_nwords;
    pkt_slice_t                pkt_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W:0]            nwords_q, idx_q, idx_nx;
    logic [WORD_W-1:0]         word_q;
    logic                      valid_q, last_q;
    logic [31:0]               cnt_q;

    assign grant       = !rst_i && (state_q == ST_IDLE) && enable_i && (src_valid_i != 2'b00);
    assign src_ready_o = grant ? gnt : 2'b00;
    assign hs          = valid_q && word_ready_i;
    assign idx_nx      = idx_q + 1'b1;

    trdb_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (src_valid_i),
        .advance (grant),
        .gnt     (gnt)
    );

    assign sel_bits   = gnt[1] ? src_bits_i[2*PACKET_TOTAL-1:PACKET_TOTAL] : src_bits_i[PACKET_TOTAL-1:0];
    assign sel_len    = gnt[1] ? src_len_i[2*LEN_W-1:LEN_W] : src_len_i[LEN_W-1:0];
    assign clamp_len  = (sel_len > LEN_W'(PACKET_TOTAL)) ? LEN_W'(PACKET_TOTAL) : sel_len;
    assign sel_nwords = ({1'b0, clamp_len} + (LEN_W+1)'(WORD_W-1)) >> SHIFT;

`ifdef TRDB_PKT_HEADER_EN
    logic             src_q;
    logic [WORD_W-1:0] hdr_word;

    // Header word: magic, source id and clamped length of the packet being granted.
    always_comb begin
        hdr_word                 = '0;
        hdr_word[31:24]          = HDR_MAGIC;
        hdr_word[16]             = gnt[1];
        hdr_word[LEN_W-1:0]      = clamp_len;
    end
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant leaves IDLE unless a zero-length packet has nothing to emit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
`ifdef TRDB_PKT_HEADER_EN
                    state_d = ST_HDR;
`else
                    if (sel_nwords != '0) state_d = ST_SEND;
`endif
                end
            end
`ifdef TRDB_PKT_HEADER_EN
            ST_HDR: begin
                if (hs) state_d = (nwords_q == '0) ? ST_IDLE : ST_SEND;
            end
`endif
            ST_SEND: begin
                if (hs && last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch the granted packet and keep the registered word stream one step ahead.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_q    <= '0;
            len_q    <= '0;
            nwords_q <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef TRDB_PKT_HEADER_EN
            src_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        pkt_q.flat <= sel_bits;
                        len_q      <= clamp_len;
                        nwords_q   <= sel_nwords;
                        idx_q      <= '0;
`ifdef TRDB_PKT_HEADER_EN
                        src_q      <= gnt[1];
                        word_q     <= hdr_word;
                        valid_q    <= 1'b1;
                        last_q     <= (sel_nwords == '0);
`else
                        if (sel_nwords != '0) begin
                            word_q  <= sel_bits[WORD_W-1:0] & tail_mask({1'b0, clamp_len}, '0);
                            valid_q <= 1'b1;
                            last_q  <= (sel_nwords == (LEN_W+1)'(1));
                        end
`endif
                    end
                end
`ifdef TRDB_PKT_HEADER_EN
                ST_HDR: begin
                    if (hs) begin
                        if (nwords_q == '0) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            cnt_q   <= cnt_q + 32'd1;
                        end else begin
                            word_q <= pkt_q.words[0] & tail_mask({1'b0, len_q}, '0);
                            last_q <= (nwords_q == (LEN_W+1)'(1));
                        end
                    end
                end
`endif
                ST_SEND: begin
                    if (hs) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            cnt_q   <= cnt_q + 32'd1;
                        end else begin
                            idx_q  <= idx_nx;
                            word_q <= pkt_q.words[idx_nx[IDX_W-1:0]] & tail_mask({1'b0, len_q}, idx_nx);
                            last_q <= (idx_nx == (nwords_q - 1'b1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign word_last_o  = last_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign pkt_cnt_o    = cnt_q;

endmodule

// File: tb/tb_trdb_packet_sched.sv
// tb_trdb_packet_sched: directed and randomized checks of trdb_packet_sched against a
// packet-level reference model (expected word queue, round-robin pointer, packet count).
module tb_trdb_packet_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   src_valid;
    logic [1:0]   src_ready_o;
    logic [255:0] src_bits;
    logic [15:0]  src_len;
    logic [31:0]  word_o;
    logic         word_valid_o;
    logic         word_last_o;
    logic         word_ready;
    logic         busy_o;
    logic [31:0]  pkt_cnt_o;

    int checks = 0;
    int errors = 0;

    // stimulus controls
    logic [1:0]   reload;
    logic         rand_len;
    int           fixed_len;
    int           ready_mode;
    logic [1:0]   last_gnt_seen;

    // reference model
    typedef struct { logic [31:0] w; logic l; } exp_word_t;
    exp_word_t    exp_q[$];
    int           model_cnt;
    logic         model_last;
    logic         idle;
    logic [1:0]   mg;
    exp_word_t    front;

    always #5 clk = ~clk;

    trdb_packet_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .src_valid_i  (src_valid),
        .src_ready_o  (src_ready_o),
        .src_bits_i   (src_bits),
        .src_len_i    (src_len),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_last_o  (word_last_o),
        .word_ready_i (word_ready),
        .busy_o       (busy_o),
        .pkt_cnt_o    (pkt_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int s, input int len, input logic [127:0] bits);
        src_valid[s]          = 1'b1;
        src_len[s*8 +: 8]     = 8'(len);
        src_bits[s*128 +: 128] = bits;
    endtask

    function automatic logic [127:0] randBits();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected words of the packet currently offered by source s.
    function automatic void pushPacket(input int s);
        logic [127:0] bits, masked;
        int len, nw;
        exp_word_t e;
        bits = src_bits[s*128 +: 128];
        len  = int'(src_len[s*8 +: 8]);
        if (len > 128) len = 128;
        masked = (len == 128) ? bits : (bits & ((128'd1 << len) - 128'd1));
        nw = (len + 31) / 32;
`ifdef TRDB_PKT_HEADER_EN
        e.w = 32'hA500_0000 | (32'(s) << 16) | 32'(len);
        e.l = (nw == 0);
        exp_q.push_back(e);
`endif
        for (int k = 0; k < nw; k++) begin
            e.w = masked[k*32 +: 32];
            e.l = (k == nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Model: compare the stream against expected words, predict grants and the count.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("ready_in_reset", src_ready_o, 2'b00);
            exp_q.delete();
            model_cnt  = 0;
            model_last = 1'b1;
        end else begin
            idle = (exp_q.size() == 0);
            checkOutput("busy", busy_o, !idle);
            checkOutput("word_valid", word_valid_o, !idle);
            checkOutput("pkt_cnt", pkt_cnt_o, model_cnt);
            if (!idle && word_valid_o) begin
                front = exp_q[0];
                checkOutput("word", word_o, front.w);
                checkOutput("word_last", word_last_o, front.l);
                if (word_ready) begin
                    void'(exp_q.pop_front());
                    if (front.l) model_cnt++;
                end
            end
            mg = 2'b00;
            if (idle && enable && (src_valid != 2'b00)) begin
                if (src_valid == 2'b11) mg = model_last ? 2'b01 : 2'b10;
                else                    mg = src_valid;
            end
            checkOutput("src_ready", src_ready_o, mg);
            if (mg != 2'b00) begin
                pushPacket(mg[1] ? 1 : 0);
                model_last = mg[1];
            end
        end
    end

    // One clock: note grants, then let granted sources reload or go quiet.
    task automatic stepCycle();
        logic [1:0] g;
        @(negedge clk);
        g = src_ready_o;
        if (g != 2'b00) last_gnt_seen = g;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (g[s]) begin
                if (reload[s]) applyStimulus(s, rand_len ? int'($urandom_range(0, 160)) : fixed_len, randBits());
                else           src_valid[s] = 1'b0;
            end
        end
        case (ready_mode)
            1:       word_ready = ~word_ready;
            2:       word_ready = 1'($urandom_range(0, 1));
            default: word_ready = 1'b1;
        endcase
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (((src_valid != 2'b00) || busy_o) && (n < budget));
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("[TB] FAIL %s: waited=%0d cycles limit=%0d", tag, n, budget);
        end
    endtask

    int cnt_before;

    initial begin
        rst = 1'b1; enable = 1'b0; src_valid = 2'b00; src_bits = '0; src_len = '0;
        word_ready = 1'b1; reload = 2'b00; rand_len = 1'b0; fixed_len = 32; ready_mode = 0;
        last_gnt_seen = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_word_valid", word_valid_o, 1'b0);
        checkOutput("rst_word_last", word_last_o, 1'b0);
        checkOutput("rst_word", word_o, 32'h0);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_pkt_cnt", pkt_cnt_o, 32'h0);
        checkOutput("rst_src_ready", src_ready_o, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1;

        $display("[TB] single packet, len=70");
        applyStimulus(0, 70, {32'h0000_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678});
        waitIdle("single_done", 40);
        checkOutput("single_pkt_cnt", pkt_cnt_o, 32'd1);

        $display("[TB] tie, both sources len=32");
        reload = 2'b11; rand_len = 1'b0; fixed_len = 32;
        applyStimulus(0, 32, randBits());
        applyStimulus(1, 32, randBits());
        repeat (12) stepCycle();
        reload = 2'b00;
        waitIdle("tie_done", 40);

        $display("[TB] backpressure, len=128");
        ready_mode = 1;
        applyStimulus(0, 128, randBits());
        waitIdle("bp_done", 60);
        ready_mode = 0; word_ready = 1'b1;

        $display("[TB] zero length from source 1");
        cnt_before = model_cnt;
        applyStimulus(1, 0, randBits());
        waitIdle("len0_done", 20);
`ifdef TRDB_PKT_HEADER_EN
        checkOutput("len0_pkt_cnt", pkt_cnt_o, 32'(cnt_before + 1));
`else
        checkOutput("len0_pkt_cnt", pkt_cnt_o, 32'(cnt_before));
`endif

        $display("[TB] enable dropped mid-packet with source 1 pending");
        applyStimulus(0, 128, randBits());
        stepCycle();
        applyStimulus(1, 40, randBits());
        stepCycle();
        stepCycle();
        enable = 1'b0;
        repeat (10) stepCycle();
        checkOutput("en_low_no_grant", src_ready_o, 2'b00);
        checkOutput("en_low_idle", busy_o, 1'b0);
        enable = 1'b1;
        waitIdle("en_resume_done", 40);

        $display("[TB] reset mid-packet");
        applyStimulus(0, 128, randBits());
        repeat (3) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("rst_mid_valid", word_valid_o, 1'b0);
        checkOutput("rst_mid_cnt", pkt_cnt_o, 32'h0);
        rst = 1'b0;
        applyStimulus(0, 32, randBits());
        applyStimulus(1, 32, randBits());
        last_gnt_seen = 2'b00;
        stepCycle();
        checkOutput("post_rst_first_tie", last_gnt_seen, 2'b01);
        waitIdle("post_rst_done", 40);

        $display("[TB] randomized traffic");
        reload = 2'b11; rand_len = 1'b1; ready_mode = 2;
        applyStimulus(0, int'($urandom_range(0, 160)), randBits());
        applyStimulus(1, int'($urandom_range(0, 160)), randBits());
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            stepCycle();
        end
        reload = 2'b00; enable = 1'b1; ready_mode = 0;
        waitIdle("random_done", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
